// File: rtl/move_controller_pkg.sv
// Shared definitions for the connect-four move controller: cell codes,
// default board geometry and the controller state encoding.
package move_controller_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int DEF_ROWS = 7;
  localparam int DEF_COLS = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DONE,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/move_controller.sv
// Drops the current player's piece into the lowest free cell of a column by
// scanning the board RAM bottom-up, and wipes the board on request.
module move_controller
  import move_controller_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  input  logic       clear,
  input  logic       game_over,
  input  logic [1:0] ram_q,
  output logic [5:0] ram_address,
  output logic [1:0] ram_data,
  output logic       ram_wren,
  output logic       move_ready,
  output logic       done,
  output logic       move_ok,
  output logic [2:0] move_row,
  output logic [1:0] current_player,
  output logic       board_enable,
  output logic       draw
);

  localparam logic [5:0] CELLS     = 6'(ROWS * COLS);
  localparam logic [5:0] LAST_ADDR = 6'(ROWS * COLS - 1);
  localparam logic [5:0] COLS_W    = 6'(COLS);
  localparam logic [3:0] COLS_LIM  = 4'(COLS);
  localparam logic [2:0] TOP_ROW   = 3'(ROWS - 1);

  state_t     state, state_nxt;
  logic [2:0] row, row_nxt;
  logic [2:0] col, col_nxt;
  logic [5:0] move_cnt, cnt_nxt;
  logic       res_ok, res_ok_nxt;
  logic [1:0] player_nxt;
  logic [5:0] addr_nxt;
  logic [1:0] data_nxt;
  logic       wren_nxt;
  logic       done_nxt;
  logic       ok_nxt;
  logic [2:0] mrow_nxt;

  assign move_ready   = (state == S_IDLE);
  assign board_enable = (state == S_IDLE);
  assign draw         = (move_cnt == CELLS);

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    col_nxt    = col;
    cnt_nxt    = move_cnt;
    res_ok_nxt = res_ok;
    player_nxt = current_player;
    addr_nxt   = ram_address;
    data_nxt   = ram_data;
    wren_nxt   = 1'b0;
    done_nxt   = 1'b0;
    ok_nxt     = 1'b0;
    mrow_nxt   = 3'd0;
    case (state)
      S_IDLE: begin
        if (clear) begin
          state_nxt = S_CLEAR;
          addr_nxt  = 6'd0;
          data_nxt  = CELL_EMPTY;
          wren_nxt  = 1'b1;
        end else if (move_valid) begin
          row_nxt = 3'd0;
          if (game_over || draw || ({1'b0, move_col} >= COLS_LIM)) begin
            state_nxt  = S_DONE;
            res_ok_nxt = 1'b0;
          end else begin
            state_nxt = S_READ;
            col_nxt   = move_col;
          end
        end
      end
      S_READ: begin
        addr_nxt  = {3'b000, row} * COLS_W + {3'b000, col};
        state_nxt = S_WAIT;
      end
      S_WAIT:  state_nxt = S_CHECK;
      // ram_q now reflects the address issued in READ
      S_CHECK: begin
        if (ram_q == CELL_EMPTY) begin
          state_nxt  = S_WRITE;
          wren_nxt   = 1'b1;
          data_nxt   = current_player;
          res_ok_nxt = 1'b1;
        end else if (row < TOP_ROW) begin
          row_nxt   = row + 3'd1;
          state_nxt = S_READ;
        end else begin
          state_nxt  = S_DONE;
          res_ok_nxt = 1'b0;
        end
      end
      S_WRITE: state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
        ok_nxt    = res_ok;
        mrow_nxt  = res_ok ? row : 3'd0;
        if (res_ok) begin
          player_nxt = (current_player == CELL_P1) ? CELL_P2 : CELL_P1;
          if (move_cnt != CELLS) cnt_nxt = move_cnt + 6'd1;
        end
      end
      S_CLEAR: begin
        if (ram_address == LAST_ADDR) begin
          state_nxt  = S_IDLE;
          player_nxt = CELL_P1;
          cnt_nxt    = 6'd0;
          row_nxt    = 3'd0;
        end else begin
          addr_nxt = ram_address + 6'd1;
          data_nxt = CELL_EMPTY;
          wren_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      row            <= 3'd0;
      col            <= 3'd0;
      move_cnt       <= 6'd0;
      res_ok         <= 1'b0;
      current_player <= CELL_P1;
      ram_address    <= 6'd0;
      ram_data       <= CELL_EMPTY;
      ram_wren       <= 1'b0;
      done           <= 1'b0;
      move_ok        <= 1'b0;
      move_row       <= 3'd0;
    end else begin
      state          <= state_nxt;
      row            <= row_nxt;
      col            <= col_nxt;
      move_cnt       <= cnt_nxt;
      res_ok         <= res_ok_nxt;
      current_player <= player_nxt;
      ram_address    <= addr_nxt;
      ram_data       <= data_nxt;
      ram_wren       <= wren_nxt;
      done           <= done_nxt;
      move_ok        <= ok_nxt;
      move_row       <= mrow_nxt;
    end
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter ROWS, default 7, board row count.
REQ-002 SHALL have parameter COLS, default 7, board column count.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 move_valid  input  1  request to drop current player's piece into move_col.
REQ-006 move_col  input  3  target column, 0..COLS-1.
REQ-007 clear  input  1  request to wipe board and restart game.
REQ-008 game_over  input  1  level from win detector; blocks further moves.
REQ-009 ram_q  input  2  board RAM read data.
REQ-010 ram_address  output  6  board RAM address, registered, = row*COLS+col, row 0 = bottom.
REQ-011 ram_data  output  2  board RAM write data.
REQ-012 ram_wren  output  1  board RAM write enable.
REQ-013 move_ready  output  1  high only in IDLE; request accepted on edge where move_ready and move_valid are both high.
REQ-014 done  output  1  one-cycle pulse ending each move attempt.
REQ-015 move_ok  output  1  valid with done; 1 = piece written.
REQ-016 move_row  output  3  valid with done; row written (0 when move_ok=0).
REQ-017 current_player  output  2  player to move: 2'b01 or 2'b10.
REQ-018 board_enable  output  1  high in IDLE, low otherwise; drives board-scan enable.
REQ-019 draw  output  1  high when move count = ROWS*COLS.

Function
REQ-020 Cell encoding SHALL be 00 empty, 01 player 1, 10 player 2.
REQ-021 FSM states SHALL be IDLE, READ, WAIT, CHECK, WRITE, DONE, CLEAR; every non-IDLE state except CLEAR lasts one cycle.
REQ-022 IDLE: clear -> CLEAR; else accepted move with game_over=1, draw=1, or move_col>=COLS -> DONE with move_ok=0; else accepted move -> READ, row=0.
REQ-023 clear SHALL take priority over simultaneous move_valid in IDLE; move_valid and clear outside IDLE SHALL be ignored.
REQ-024 READ drives ram_address=row*COLS+col; WAIT holds; CHECK samples ram_q (2 cycles after address update).
REQ-025 CHECK: ram_q=00 -> WRITE; ram_q!=00 and row<ROWS-1 -> row+1, READ; row=ROWS-1 -> DONE, move_ok=0 (column full).
REQ-026 WRITE SHALL assert ram_wren for exactly one cycle with ram_data=current_player, address unchanged.
REQ-027 DONE SHALL pulse done; on move_ok=1 toggle current_player and increment move count; on move_ok=0 change neither.
REQ-028 Latency, accept edge to done-high cycle: 5+3k cycles for column with k occupied cells (k<ROWS), 3*ROWS+1 for full column, 1 for rejected request.
REQ-029 CLEAR SHALL write 00 to addresses 0..ROWS*COLS-1, one per cycle with ram_wren=1, then return to IDLE with current_player=01, move count 0, no done pulse.
REQ-030 ram_wren SHALL be 0 in every state except WRITE and CLEAR.
REQ-031 Move count SHALL be 6 bits and saturate at ROWS*COLS.

Reset
REQ-032 reset SHALL asynchronously force IDLE, current_player=01, move count=0, row=0, ram_address=0, ram_data=00, ram_wren=0, done=0, move_ok=0, move_row=0.
REQ-033 reset mid-move or mid-clear SHALL abort without completing the pending write or issuing done.

Structure
REQ-034 Shared package SHALL hold cell encodings, ROWS/COLS defaults, and FSM state encoding.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Empty board, move col 3 -> done at cycle 5, move_ok=1, move_row=0, write 01 to address 3, current_player=10.
REQ-037 Col 2 holding 3 pieces, move -> done at cycle 14, move_row=3, write to address 23.
REQ-038 Full column 0, move -> done at cycle 22, move_ok=0, no ram_wren, current_player unchanged.
REQ-039 move_col=7 or game_over=1 -> done at cycle 1, move_ok=0, no RAM read or write.
REQ-040 clear and move_valid same edge -> 49 consecutive writes of 00 (addresses 0..48), then IDLE, current_player=01, no done.
REQ-041 reset asserted during WRITE -> ram_wren low immediately, IDLE, no done; 49 successful moves -> draw=1, next move rejected.
